// File: rtl/frame_buffer_arbiter_pkg.sv
// Shared constants and state encoding for the frame buffer arbiter.
// The RAM holds two banks of FRAME_WORDS pixel words each.
package frame_buffer_arbiter_pkg;

    localparam int DEF_ADDR_W  = 7;
    localparam int DEF_DATA_W  = 24;
    localparam int FRAME_WORDS = 128;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/frame_buffer_arbiter_bank_clear_engine.sv
// Sweeps every word of the back bank with a latched fill colour.
// The sweep advances only on cycles where the display does not own the RAM port.
module frame_buffer_arbiter_bank_clear_engine
    import frame_buffer_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] color_i,
    input  logic              active_i,
    input  logic              stall_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] color_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;

    assign wr_en_o = active_i & ~stall_i;
    assign addr_o  = cnt_q;
    assign color_o = color_q;
    // The last word is written in the same cycle the counter wraps back to zero.
    assign done_o  = wr_en_o & (cnt_q == ADDR_W'(FRAME_WORDS - 1));

    always_comb begin
        cnt_d   = cnt_q;
        color_d = color_q;
        if (start_i) begin
            cnt_d   = '0;
            color_d = color_i;
        end else if (wr_en_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            color_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            color_q <= color_d;
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame RAM arbiter: display reads beat bank clears beat game writes,
// and the front/back swap is deferred to the display's frame boundary.
module frame_buffer_arbiter
    import frame_buffer_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_rd,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_req,
    input  logic [DATA_W-1:0] clr_color,
    input  logic              swap_req,
    input  logic              frame_sync,
    output logic              front_bank,
    output logic              busy,
    output logic              swap_done,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state_q, state_d;
    logic   front_q, front_d;
    logic   pend_q, pend_d;
    logic   vld_p1_q;
    logic   swap_done_q;
    logic   swap_fire;
    logic   clr_start;

    logic              clr_wr;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_fill;
    logic              we_sel;

    frame_buffer_arbiter_bank_clear_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank_clear_engine (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (clr_start),
        .color_i  (clr_color),
        .active_i (state_q == CLEAR),
        .stall_i  (disp_rd),
        .wr_en_o  (clr_wr),
        .addr_o   (clr_addr),
        .color_o  (clr_fill),
        .done_o   (clr_done)
    );

    assign wr_ack     = wr_req & ~disp_rd & (state_q == IDLE) & ~rst;
    assign front_bank = front_q;
    assign busy       = (state_q != IDLE) | pend_q;
    assign swap_done  = swap_done_q;
    assign disp_valid = vld_p1_q;
    assign disp_data  = mem_rdata;
    assign mem_we     = we_sel & ~rst;

    always_comb begin
        mem_addr  = {front_q, disp_addr};
        we_sel    = 1'b0;
        mem_wdata = '0;
        if (disp_rd) begin
            mem_addr = {front_q, disp_addr};
        end else if (clr_wr) begin
            mem_addr  = {~front_q, clr_addr};
            we_sel    = 1'b1;
            mem_wdata = clr_fill;
        end else if (wr_ack) begin
            mem_addr  = {~front_q, wr_addr};
            we_sel    = 1'b1;
            mem_wdata = wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        front_d   = front_q;
        pend_d    = pend_q;
        clr_start = 1'b0;
        swap_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    clr_start = 1'b1;
                    state_d   = CLEAR;
                    if (swap_req) pend_d = 1'b1;
                end else if (swap_req) begin
                    // A swap requested on the frame boundary itself executes immediately.
                    if (frame_sync) begin
                        front_d   = ~front_q;
                        pend_d    = 1'b0;
                        swap_fire = 1'b1;
                    end else begin
                        pend_d  = 1'b1;
                        state_d = SWAP_WAIT;
                    end
                end
            end
            CLEAR: begin
                if (swap_req) pend_d = 1'b1;
                if (clr_done) state_d = (pend_q | swap_req) ? SWAP_WAIT : IDLE;
            end
            SWAP_WAIT: begin
                if (frame_sync) begin
                    front_d   = ~front_q;
                    pend_d    = 1'b0;
                    swap_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            front_q     <= 1'b0;
            pend_q      <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            pend_q      <= pend_d;
            swap_done_q <= swap_fire;
        end
    end

    // read data returns from the RAM one cycle after the address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= disp_rd;
        end
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed test of frame_buffer_arbiter against a behavioural RAM with
// hand-computed expectations for reads, writes, clears, swaps and reset.
module tb_frame_buffer_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_rd;
    logic [6:0]  disp_addr;
    logic [23:0] disp_data;
    logic        disp_valid;
    logic        wr_req;
    logic [6:0]  wr_addr;
    logic [23:0] wr_data;
    logic        wr_ack;
    logic        clr_req;
    logic [23:0] clr_color;
    logic        swap_req;
    logic        frame_sync;
    logic        front_bank;
    logic        busy;
    logic        swap_done;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;

    logic        use_ram;
    logic [23:0] rd_force;
    logic [23:0] ram_rd;
    logic [23:0] ram [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_rd <= ram[mem_addr];
    end

    assign mem_rdata = use_ram ? ram_rd : rd_force;

    frame_buffer_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .disp_rd    (disp_rd),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .clr_req    (clr_req),
        .clr_color  (clr_color),
        .swap_req   (swap_req),
        .frame_sync (frame_sync),
        .front_bank (front_bank),
        .busy       (busy),
        .swap_done  (swap_done),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int bad;
        int bcyc;

        rst = 1'b1; disp_rd = 1'b0; disp_addr = '0; wr_req = 1'b1; wr_addr = 7'd3;
        wr_data = 24'h123456; clr_req = 1'b0; clr_color = '0; swap_req = 1'b0;
        frame_sync = 1'b0; use_ram = 1'b0; rd_force = '0;

        // Reset state, with a pending write that must not reach the RAM
        tick(); tick();
        @(negedge clk);
        chk("rst_front", front_bank, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", disp_valid, 0);
        chk("rst_swapdone", swap_done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_ack", wr_ack, 0);
        wr_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Display read with pass-through data one cycle later
        disp_rd = 1'b1; disp_addr = 7'd5; rd_force = 24'hABCDEF;
        @(negedge clk);
        chk("rd_addr", mem_addr, 8'h05);
        chk("rd_we", mem_we, 0);
        tick();
        disp_rd = 1'b0;
        @(negedge clk);
        chk("rd_valid", disp_valid, 1);
        chk("rd_data", disp_data, 24'hABCDEF);
        tick();
        @(negedge clk);
        chk("rd_valid_drop", disp_valid, 0);
        tick();

        // Game write blocked by display reads, then accepted
        wr_req = 1'b1; wr_addr = 7'd3; wr_data = 24'h123456; disp_rd = 1'b1;
        @(negedge clk);
        chk("wr_blk0", wr_ack, 0);
        tick();
        @(negedge clk);
        chk("wr_blk1", wr_ack, 0);
        tick();
        disp_rd = 1'b0;
        @(negedge clk);
        chk("wr_ack", wr_ack, 1);
        chk("wr_addr", mem_addr, 8'h83);
        chk("wr_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 24'h123456);
        chk("wr_front", front_bank, 0);
        tick();
        wr_req = 1'b0;
        use_ram = 1'b1;

        // Clear with no display traffic
        clr_req = 1'b1; clr_color = 24'h000007;
        tick();
        clr_req = 1'b0; clr_color = 24'hFFFFFF;
        n = 0; bad = 0; bcyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
            bcyc++;
            if (mem_we) begin
                if (mem_addr !== 8'(8'h80 + n) || mem_wdata !== 24'h000007) bad++;
                n++;
            end
            tick();
        end
        tick();
        chk("clr1_busy_cycles", bcyc, 128);
        chk("clr1_writes", n, 128);
        chk("clr1_bad_writes", bad, 0);

        // Clear interleaved with display reads every other cycle
        clr_req = 1'b1; clr_color = 24'h00000A;
        tick();
        clr_req = 1'b0;
        n = 0; bad = 0; bcyc = 0;
        for (int i = 0; i < 600; i++) begin
            disp_rd = ~i[0];
            @(negedge clk);
            if (!busy) break;
            bcyc++;
            if (mem_we) begin
                if (disp_rd || mem_addr !== 8'(8'h80 + n) || mem_wdata !== 24'h00000A) bad++;
                n++;
            end
            tick();
        end
        disp_rd = 1'b0;
        tick();
        chk("clr2_busy_cycles", bcyc, 256);
        chk("clr2_writes", n, 128);
        chk("clr2_bad_writes", bad, 0);

        // frame_sync alone does nothing
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        @(negedge clk);
        chk("fs_idle_front", front_bank, 0);
        chk("fs_idle_swapdone", swap_done, 0);
        tick();

        // Swap request waits for frame_sync; writes and clears are refused meanwhile
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 10) clr_req = 1'b1;
            if (i == 11) clr_req = 1'b0;
            if (i == 20) swap_req = 1'b1;
            if (i == 21) swap_req = 1'b0;
            tick();
        end
        wr_req = 1'b1; wr_addr = 7'd9;
        @(negedge clk);
        chk("sw_wait_front", front_bank, 0);
        chk("sw_wait_busy", busy, 1);
        chk("sw_wait_ack", wr_ack, 0);
        tick();
        wr_req = 1'b0;
        frame_sync = 1'b1; disp_rd = 1'b1; disp_addr = 7'd2;
        @(negedge clk);
        chk("sw_rd_oldbank", mem_addr, 8'h02);
        tick();
        frame_sync = 1'b0; disp_addr = 7'd0;
        @(negedge clk);
        chk("sw_front", front_bank, 1);
        chk("sw_done", swap_done, 1);
        chk("sw_busy", busy, 0);
        chk("sw_rd_newbank", mem_addr, 8'h80);
        tick();
        disp_addr = 7'd127;
        @(negedge clk);
        chk("sw_done_drop", swap_done, 0);
        chk("sw_rd0_data", disp_data, 24'h00000A);
        tick();
        disp_rd = 1'b0;
        @(negedge clk);
        chk("sw_rd127_data", disp_data, 24'h00000A);
        tick();

        // swap_req coinciding with frame_sync swaps on that edge
        swap_req = 1'b1; frame_sync = 1'b1;
        tick();
        swap_req = 1'b0; frame_sync = 1'b0;
        @(negedge clk);
        chk("imm_front", front_bank, 0);
        chk("imm_done", swap_done, 1);
        chk("imm_busy", busy, 0);
        tick();

        // Swap requested mid-clear must not fire before the clear completes
        clr_req = 1'b1; clr_color = 24'h000055;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 128; i++) begin
            swap_req = (i == 20);
            frame_sync = (i == 50);
            tick();
        end
        swap_req = 1'b0; frame_sync = 1'b0;
        @(negedge clk);
        chk("mid_front", front_bank, 0);
        chk("mid_busy", busy, 1);
        chk("mid_we_idle", mem_we, 0);
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        @(negedge clk);
        chk("mid_swap_front", front_bank, 1);
        chk("mid_swap_done", swap_done, 1);
        chk("mid_swap_busy", busy, 0);
        tick();

        // Asynchronous reset in the middle of a clear
        clr_req = 1'b1; clr_color = 24'h000033;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        @(negedge clk);
        chk("rc_addr40", mem_addr, 8'h28);
        chk("rc_we40", mem_we, 1);
        #1 rst = 1'b1;
        #1;
        chk("rc_busy", busy, 0);
        chk("rc_we", mem_we, 0);
        chk("rc_front", front_bank, 0);
        chk("rc_valid", disp_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        clr_req = 1'b1; clr_color = 24'h000044;
        tick();
        clr_req = 1'b0;
        @(negedge clk);
        chk("rc_restart_addr", mem_addr, 8'h80);
        chk("rc_restart_data", mem_wdata, 24'h000044);
        chk("rc_restart_busy", busy, 1);
        for (int i = 0; i < 130; i++) tick();
        @(negedge clk);
        chk("rc_final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
- Owns the single-port 2x128x24 frame RAM. Splits it into a front bank (scanned by the matrix display) and a back bank (drawn by game logic).
- Arbitrates three requesters: display reads, game pixel writes, and an internal bank-clear engine. Display reads always win.
- Performs a tear-free front/back swap aligned to the display's frame boundary.

Parameters:
- ADDR_W, 7, pixel-word address width per bank (128 words = 16 anodes x 8 rows).
- DATA_W, 24, pixel word width (8 x RGB triplet PWM compare data).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- disp_rd  in  1  display read strobe.
- disp_addr  in  ADDR_W  display word address within the front bank.
- disp_data  out  DATA_W  read data; valid when disp_valid=1.
- disp_valid  out  1  high exactly one cycle after an accepted disp_rd.
- wr_req  in  1  game write request; held high until acked.
- wr_addr  in  ADDR_W  back-bank word address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  combinational; the write is committed this cycle.
- clr_req  in  1  pulse; fill the back bank with clr_color.
- clr_color  in  DATA_W  fill value, sampled on clr_req.
- swap_req  in  1  pulse; request a front/back exchange.
- frame_sync  in  1  one-cycle pulse at display frame start (anode index wraps 15->0).
- front_bank  out  1  current front bank index.
- busy  out  1  high while clear is running or a swap is pending.
- swap_done  out  1  one-cycle pulse in the cycle after the swap.
- mem_addr  out  ADDR_W+1  RAM address, formed as {bank, word}.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, one-cycle latency.

Behaviour:
- Reset (async): front_bank=0, state=IDLE, clear counter=0, latched clear color=0, swap_pending=0, disp_valid=0, swap_done=0, busy=0. mem_we=0 while rst is high. A reset during a clear abandons it; the back bank keeps whatever was partially written.
- Port priority each cycle: display read > clear-engine write > game write.
- Display read:
  - If disp_rd=1: mem_addr={front_bank,disp_addr}, mem_we=0.
  - Next cycle: disp_valid=1 and disp_data=mem_rdata (pass-through).
  - disp_rd is never stalled.
- Game write:
  - wr_ack = wr_req & ~disp_rd & (state==IDLE).
  - When acked: mem_addr={~front_bank,wr_addr}, mem_we=1, mem_wdata=wr_data.
  - Back-to-back acks are allowed, one per cycle.
- Memory-port signals are combinational from the inputs and registered state (a single mux).
- States: IDLE, CLEAR, SWAP_WAIT.
- IDLE:
  - clr_req -> latch clr_color, counter=0, go to CLEAR.
  - swap_req -> swap_pending=1, go to SWAP_WAIT.
  - If clr_req and swap_req arrive together, the clear wins and swap_pending is set.
- CLEAR:
  - On every cycle without disp_rd, write {~front_bank,counter} with the latched color, then counter+1.
  - Cycles with disp_rd stall the counter.
  - After writing word 127 (counter wraps to 0): go to SWAP_WAIT if swap_pending, else IDLE.
  - clr_req during CLEAR is ignored.
  - swap_req during CLEAR sets swap_pending.
- SWAP_WAIT:
  - On frame_sync: toggle front_bank, clear swap_pending, return to IDLE. swap_done pulses the following cycle.
  - A disp_rd in the frame_sync cycle still uses the old front bank; the bank change takes effect at the clock edge.
  - Game writes are not acked in SWAP_WAIT.
  - Further swap_req pulses are absorbed (at most one swap per frame_sync).
  - clr_req is ignored.
- swap_req and frame_sync together in IDLE: the swap executes on that same edge, without waiting for the next frame.
- frame_sync in IDLE or CLEAR with no swap pending has no effect.
- busy = (state!=IDLE) | swap_pending.

Decomposition:
- Shared package: ADDR_W and DATA_W defaults, state encoding constants (IDLE=2'd0, CLEAR=2'd1, SWAP_WAIT=2'd2), and the constant FRAME_WORDS=128.
- One natural sub-module: bank_clear_engine, containing the counter, the latched color and the done flag, with a stall input driven by disp_rd.

Test Plan:
- Reset then disp_rd with disp_addr=5 and mem_rdata=24'hABCDEF -> mem_addr=8'h05 and mem_we=0; next cycle disp_valid=1 and disp_data=24'hABCDEF.
- wr_req held with wr_addr=3 and disp_rd=1 for 2 cycles, then disp_rd=0 -> wr_ack=0 for 2 cycles, then wr_ack=1 with mem_addr=8'h83, mem_we=1, front_bank=0.
- clr_req with clr_color=24'h000007 and no display traffic -> exactly 128 writes to 0x80..0xFF, busy high for 128 cycles, then IDLE. With disp_rd every other cycle -> 128 writes over 256 cycles.
- swap_req with no frame_sync for 1000 cycles -> front_bank stays 0 and busy=1. On frame_sync: front_bank=1 after the edge and swap_done pulses one cycle later. A subsequent disp_addr=0 read drives mem_addr=8'h80.
- swap_req issued mid-clear, then frame_sync before the clear completes -> no swap. The swap occurs on the first frame_sync after word 127 is written.
- Assert rst mid-clear at counter=40 -> all outputs return to reset values immediately. A subsequent clear starts at word 0.
